// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared states, widths and SPI mode constants for the scheduled SPI master.
package spi_master_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_H, SHIFT_L, TRAIL_H, TRAIL_L, GAP} state_t;
  localparam int BIT_W = 3;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic SS_IDLE = 1'b1;
  function automatic int cnt_w(input int div);
    return $clog2(div);
  endfunction
endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: one-hot pick of the first request at or after ptr, circularly.
module spi_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW = 1
)(
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] win
);
  logic [NREQ-1:0] rot, pick;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    pick = rot & -rot;
    win = en ? NREQ'({pick, pick} >> (PW'(NREQ) - ptr)) : '0;
  end
endmodule

// File: rtl/spi_master_sched.sv
// spi_master_sched: round-robin scheduler sharing one mode-0, MSB-first SPI bus
// between NREQ requesters; one byte per grant plus a trailer SCLK pulse.
module spi_master_sched
  import spi_master_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CLK_DIV = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS
);
  localparam int CW = cnt_w(CLK_DIV);
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic [7:0] tx, tx_n, rx_sh, rx_n, rx_data_n, wdata;
  logic [PW-1:0] ptr, ptr_n, win, win_n, widx;
  logic [NREQ-1:0] pick, gnt_n, done_n;
  logic [1:0] miso_sync;
  logic sclk_n, ss_n, mosi_n, busy_n, last;
  assign last = cnt == CNT_LAST;
  spi_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req(req),
    .ptr(ptr),
    .en(state == IDLE),
    .win(pick)
  );
  always_comb begin
    wdata = '0;
    widx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) begin
        wdata = req_data[8*i +: 8];
        widx = PW'(i);
      end
  end
  // Zeros shift into tx so MOSI falls to 0 after bit 0 and stays there through the trailer.
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || last) ? '0 : cnt + 1'b1;
    bit_n = bit_cnt;
    tx_n = tx;
    rx_n = rx_sh;
    rx_data_n = rx_data;
    ptr_n = ptr;
    win_n = win;
    gnt_n = gnt;
    done_n = '0;
    busy_n = busy;
    sclk_n = SCLK;
    ss_n = SS;
    mosi_n = MOSI;
    case (state)
      IDLE:
        if (|pick) begin
          state_n = SETUP;
          gnt_n = pick;
          win_n = widx;
          busy_n = 1'b1;
          ss_n = ~SS_IDLE;
          tx_n = wdata;
          mosi_n = wdata[7];
          bit_n = BIT_W'(7);
        end
      SETUP:
        if (last) begin
          state_n = SHIFT_H;
          sclk_n = ~SCLK_IDLE;
        end
      SHIFT_H:
        if (last) begin
          state_n = SHIFT_L;
          sclk_n = SCLK_IDLE;
          rx_n = {rx_sh[6:0], miso_sync[1]};
          tx_n = {tx[6:0], 1'b0};
          mosi_n = tx[6];
        end
      SHIFT_L:
        if (last) begin
          state_n = (bit_cnt == '0) ? TRAIL_H : SHIFT_H;
          sclk_n = ~SCLK_IDLE;
          bit_n = bit_cnt - 1'b1;
        end
      TRAIL_H:
        if (last) begin
          state_n = TRAIL_L;
          sclk_n = SCLK_IDLE;
        end
      TRAIL_L:
        if (last) begin
          state_n = GAP;
          ss_n = SS_IDLE;
          gnt_n = '0;
          done_n = gnt;
          rx_data_n = rx_sh;
          ptr_n = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      GAP:
        if (last) begin
          state_n = IDLE;
          busy_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      tx <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      ptr <= '0;
      win <= '0;
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      SCLK <= SCLK_IDLE;
      SS <= SS_IDLE;
      MOSI <= 1'b0;
      miso_sync <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      tx <= tx_n;
      rx_sh <= rx_n;
      rx_data <= rx_data_n;
      ptr <= ptr_n;
      win <= win_n;
      gnt <= gnt_n;
      done <= done_n;
      busy <= busy_n;
      SCLK <= sclk_n;
      SS <= ss_n;
      MOSI <= mosi_n;
      miso_sync <= {miso_sync[0], MISO};
    end
endmodule

// File: doc/spi_master_sched.md
Name: spi_master_sched

Overview:
- System-clock SPI master that shares one SPI bus between NREQ on-chip requesters.
- Round-robin arbitration; one 8-bit full-duplex transfer per grant.
- Generates SCLK/SS/MOSI and samples MISO.
- Wire format: mode 0, MSB first.
  - MOSI changes on SCLK falling edge; sampled by the slave on rising edge.
  - MISO is driven by the slave on falling edge.
  - One trailer SCLK pulse follows bit 0 so the slave returns to idle before SS rises.
- Sits between the CPU/peripheral request logic and the spi_slave-style targets on the board.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CLK_DIV, 4, SCLK half-period in clk cycles (>=2).

Ports:
- clk      input   1         system clock.
- rst_n    input   1         asynchronous active-low reset.
- req      input   NREQ      per-requester transfer request, level; must be held until done.
- req_data input   NREQ*8    tx byte for requester i at [8i+7:8i].
- gnt      output  NREQ      one-hot, high from capture until done.
- done     output  NREQ      one-cycle pulse to the granted requester at transfer end.
- rx_data  output  8         received byte; valid in the done cycle and held until the next done.
- busy     output  1         high from grant until the gap ends.
- SCLK     output  1         SPI clock, idle low.
- MOSI     output  1         SPI data out.
- MISO     input   1         SPI data in; stable through the SCLK high phase.
- SS       output  1         active-low slave select.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset values: SCLK=0, SS=1, MOSI=0, gnt=0, done=0, rx_data=0, busy=0.
  - Arbiter pointer=0, state IDLE.
  - Reset mid-transfer aborts immediately: SS=1, SCLK=0; no done pulse.
- States: IDLE, SETUP, SHIFT_H, SHIFT_L, TRAIL_H, TRAIL_L, GAP.
- A single divider counter counts CLK_DIV cycles per phase.
- A bit counter counts 7 down to 0.
- IDLE: if any req bit is high at edge 0, at edge 1:
  - winner = first requester at or after pointer, circularly;
  - gnt[winner]=1, busy=1, SS=0;
  - tx shift register = req_data of winner; MOSI = bit7;
  - enter SETUP.
- SETUP: CLK_DIV cycles, SCLK=0, then SHIFT_H.
- SHIFT_H: SCLK=1 for CLK_DIV cycles.
  - On the last cycle of the phase, shift MISO into the rx register LSB; bits accumulate MSB first.
- SHIFT_L: SCLK=0 for CLK_DIV cycles; MOSI updates to the next bit on entry.
  - After bit 0's low phase, go to TRAIL_H; otherwise go back to SHIFT_H.
- TRAIL_H / TRAIL_L: one extra SCLK pulse (CLK_DIV high, CLK_DIV low), MOSI=0, MISO ignored.
- End of TRAIL_L, edge 1+19*CLK_DIV (77 at default):
  - SS=1, gnt=0, done[winner]=1 for 1 cycle;
  - rx_data updated; pointer=winner+1, mod NREQ.
- GAP: CLK_DIV cycles with SS=1, then IDLE with busy=0.
- Back-to-back spacing: minimum SS-low-to-SS-low is 20*CLK_DIV+1 cycles.
- req and req_data are sampled only in IDLE.
  - Deasserting req mid-transfer does not abort; done still pulses.
  - Requests that arrive during a transfer wait.
- Simultaneous requests: round-robin order.
  - No requester is granted twice while another holding req waits.
- MISO passes through a 2-flop synchronizer.
  - With CLK_DIV>=2, sample at the end of the high phase; sync latency stays inside the phase.
- req with no pending bits: no activity, SCLK stays 0.

Decomposition:
- Package spi_master_pkg holds:
  - state encodings (localparams);
  - bit-count width;
  - CLK_DIV counter width function ($clog2);
  - the SPI mode constants.
- One sub-module, spi_rr_arbiter, is natural:
  - inputs: req, pointer, enable;
  - outputs: one-hot winner;
  - combinational rotate and priority-encode.

Test Plan:
- Single transfer: NREQ=2, CLK_DIV=4, req[0]=1, data 8'hA5, slave returns 8'h3C.
  - SS low at edge 1.
  - MOSI bits 1,0,1,0,0,1,0,1 stable at each SCLK rise.
  - 9 SCLK rises.
  - done[0] at edge 77, rx_data=8'h3C.
- Simultaneous req=2'b11, data0=8'h01, data1=8'h80.
  - Grant order 0, then 1.
  - Second SS low 81 cycles after the first.
  - done[1] rx correct.
- Fairness: req[0] held continuously, req[1] pulsed high.
  - req[1] served right after the current transfer.
  - Never two consecutive grants to 0 while req[1]=1.
- Reset mid-transfer: rst_n low at bit 3.
  - SS=1, SCLK=0 asynchronously; no done pulse.
  - After release, a new req[1] transfer completes normally; pointer restarts at 0.
- req dropped after grant: req[0] low at edge 10.
  - Transfer completes, done[0] pulses.
  - Bus returns idle after GAP.
- Boundary: CLK_DIV=2, data 8'hFF / MISO tied 0.
  - Done at edge 39, rx_data=8'h00.
  - MOSI=0 during the trailer pulse.
